// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared command codes, ASCII bytes and sequencer states
// for the host-reply frame path.
package tx_frame_pkg;

    localparam int CMD_IDLE  = 0;
    localparam int CMD_ID    = 1;
    localparam int CMD_START = 3;
    localparam int CMD_DATA  = 4;
    localparam int CMD_PPR   = 5;
    localparam int CMD_STOP  = 6;
    localparam int CMD_TEMP  = 7;

    localparam logic [7:0] A_H    = 8'h48;
    localparam logic [7:0] A_E    = 8'h65;
    localparam logic [7:0] A_L    = 8'h6C;
    localparam logic [7:0] A_O    = 8'h6F;
    localparam logic [7:0] A_G    = 8'h47;
    localparam logic [7:0] A_DOT  = 8'h2E;
    localparam logic [7:0] A_STAR = 8'h2A;
    localparam logic [7:0] A_PLUS = 8'h2B;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } seqState_t;

endpackage

// File: rtl/tx_frame_rom.sv
// tx_frame_rom: maps (cmd, byte index, payload) to the frame byte
// and reports the frame length; zero length marks an unknown code.
module tx_frame_rom
    import tx_frame_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PPR_W  = 16,
    parameter int CMD_W  = 4,
    parameter int LEN_W  = 5
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [LEN_W-1:0]  idx,
    input  logic [DATA_W-1:0] data,
    input  logic [PPR_W-1:0]  ppr,
    output logic [7:0]        byteOut,
    output logic [LEN_W-1:0]  len
);

    localparam int DB = DATA_W / 8;
    localparam int PB = PPR_W / 8;

    logic [15:0] lo16;
    int          k;

    assign lo16 = 16'(data);

    always_comb begin
        byteOut = 8'h00;
        len     = '0;
        k       = int'(idx);
        case (int'(cmd))
            CMD_ID: begin
                len = LEN_W'(7);
                unique case (1'b1)
                    (k == 0):           byteOut = A_H;
                    (k == 1):           byteOut = A_E;
                    (k == 2 || k == 3): byteOut = A_L;
                    (k == 4):           byteOut = A_O;
                    default:            byteOut = A_DOT;
                endcase
            end
            CMD_START: begin
                len     = LEN_W'(4);
                byteOut = (k < 2) ? A_G : A_DOT;
            end
            CMD_DATA: begin
                len = LEN_W'(DB);
                if (k < DB) byteOut = data[8*(DB-1-k) +: 8];
            end
            CMD_PPR: begin
                len = LEN_W'(4 + PB + DB);
                unique case (1'b1)
                    (k < 2):
                        byteOut = A_G;
                    (k >= 2 && k < 2 + PB):
                        byteOut = ppr[8*(PB+1-k) +: 8];
                    (k >= 2 + PB && k < 2 + PB + DB):
                        byteOut = data[8*(DB+PB+1-k) +: 8];
                    default:
                        byteOut = A_DOT;
                endcase
            end
            CMD_STOP: begin
                len     = LEN_W'(2);
                byteOut = (k == 0) ? A_STAR : A_PLUS;
            end
            CMD_TEMP: begin
                len = LEN_W'(4);
                unique case (1'b1)
                    (k == 0): byteOut = lo16[15:8];
                    (k == 1): byteOut = lo16[7:0];
                    default:  byteOut = A_DOT;
                endcase
            end
            default: begin
                len     = '0;
                byteOut = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: command-driven reply framer feeding the byte UART.
// Snapshots Data/PPR at accept and streams the frame over ready/valid.
module tx_frame_sequencer
    import tx_frame_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PPR_W  = 16,
    parameter int CMD_W  = 4
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              CmdValid,
    input  logic [CMD_W-1:0]  Cmd,
    output logic              CmdReady,
    input  logic [DATA_W-1:0] Data,
    input  logic [PPR_W-1:0]  PPR,
    input  logic              Abort,
    output logic [7:0]        ByteData,
    output logic              ByteValid,
    input  logic              ByteReady,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int DB      = DATA_W / 8;
    localparam int PB      = PPR_W / 8;
    localparam int MAX_LEN = (4 + PB + DB > 7) ? 4 + PB + DB : 7;
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int LEN_W   = IDX_W + 1;

    seqState_t         stateQ, stateD;
    logic [IDX_W-1:0]  idxQ, idxD;
    logic [CMD_W-1:0]  cmdQ;
    logic [DATA_W-1:0] dataQ;
    logic [PPR_W-1:0]  pprQ;
    logic              abortQ, abortD;

    logic              cmdReadyD, byteValidD, busyD, doneD, errD;
    logic [7:0]        byteDataD;

    logic              accept, lastByte;
    logic [CMD_W-1:0]  romCmd;
    logic [LEN_W-1:0]  romIdx, romLen;
    logic [DATA_W-1:0] romData;
    logic [PPR_W-1:0]  romPpr;
    logic [7:0]        romByte;

    assign accept = CmdValid && CmdReady && (Cmd != CMD_W'(CMD_IDLE));

    // At accept the ROM sees the live inputs so byte 0 lands next cycle.
    assign romCmd  = accept ? Cmd  : cmdQ;
    assign romData = accept ? Data : dataQ;
    assign romPpr  = accept ? PPR  : pprQ;
    assign romIdx  = accept ? '0 : {1'b0, idxQ} + LEN_W'(1);

    assign lastByte = ({1'b0, idxQ} + LEN_W'(1)) == romLen;

    tx_frame_rom #(
        .DATA_W(DATA_W),
        .PPR_W (PPR_W),
        .CMD_W (CMD_W),
        .LEN_W (LEN_W)
    ) uRom (
        .cmd    (romCmd),
        .idx    (romIdx),
        .data   (romData),
        .ppr    (romPpr),
        .byteOut(romByte),
        .len    (romLen)
    );

    always_comb begin
        stateD     = stateQ;
        idxD       = idxQ;
        cmdReadyD  = 1'b0;
        byteValidD = 1'b0;
        byteDataD  = 8'h00;
        busyD      = 1'b0;
        doneD      = 1'b0;
        errD       = 1'b0;
        unique case (stateQ)
            IDLE: begin
                cmdReadyD = 1'b1;
                if (accept) begin
                    idxD      = '0;
                    cmdReadyD = 1'b0;
                    busyD     = 1'b1;
                    if (romLen == '0) begin
                        stateD = DONE;
                        doneD  = 1'b1;
                        errD   = 1'b1;
                    end else begin
                        stateD     = SEND;
                        byteValidD = 1'b1;
                        byteDataD  = romByte;
                    end
                end
            end
            SEND: begin
                busyD      = 1'b1;
                byteValidD = 1'b1;
                byteDataD  = ByteData;
                if (ByteReady) begin
                    if (lastByte || abortQ || Abort) begin
                        stateD     = DONE;
                        byteValidD = 1'b0;
                        byteDataD  = 8'h00;
                        doneD      = 1'b1;
                        errD       = abortQ || Abort;
                    end else begin
                        idxD      = idxQ + IDX_W'(1);
                        byteDataD = romByte;
                    end
                end
            end
            DONE: begin
                stateD    = IDLE;
                cmdReadyD = 1'b1;
            end
            default: stateD = IDLE;
        endcase
        // Sticky abort lives only while a frame is out of IDLE.
        abortD = (stateQ == IDLE || stateD == IDLE) ? 1'b0 : (abortQ || Abort);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            stateQ    <= IDLE;
            idxQ      <= '0;
            cmdQ      <= '0;
            dataQ     <= '0;
            pprQ      <= '0;
            abortQ    <= 1'b0;
            CmdReady  <= 1'b0;
            ByteValid <= 1'b0;
            ByteData  <= 8'h00;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            abortQ    <= abortD;
            CmdReady  <= cmdReadyD;
            ByteValid <= byteValidD;
            ByteData  <= byteDataD;
            Busy      <= busyD;
            Done      <= doneD;
            Err       <= errD;
            if (accept) begin
                cmdQ  <= Cmd;
                dataQ <= Data;
                pprQ  <= PPR;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: table, hand-written and random frames checked
// against a queue-based frame model.
module tb_tx_frame_sequencer;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        CmdValid;
    logic [3:0]  Cmd;
    logic        CmdReady;
    logic [31:0] Data;
    logic [15:0] PPR;
    logic        Abort;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady;
    logic        Busy;
    logic        Done;
    logic        Err;

    int nVec = 0;
    int nMis = 0;

    logic [7:0] expQ[$];

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] data;
        logic [15:0] ppr;
        int          rmode;
        int          abortAt;
        bit          chg;
        int          expCnt;
        bit          expErr;
    } vec_t;

    vec_t tbl[8];

    tx_frame_sequencer #(
        .DATA_W(32),
        .PPR_W (16),
        .CMD_W (4)
    ) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .CmdValid (CmdValid),
        .Cmd      (Cmd),
        .CmdReady (CmdReady),
        .Data     (Data),
        .PPR      (PPR),
        .Abort    (Abort),
        .ByteData (ByteData),
        .ByteValid(ByteValid),
        .ByteReady(ByteReady),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reply frame built from the byte-level description of each command.
    function automatic void buildFrame(input logic [3:0] c,
                                       input logic [31:0] d,
                                       input logic [15:0] p);
        string s;
        expQ.delete();
        s = "";
        case (c)
            4'd1: s = "Hello..";
            4'd3: s = "GG..";
            4'd6: s = "*+";
            default: s = "";
        endcase
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
        if (c == 4'd4)
            for (int i = 3; i >= 0; i--) expQ.push_back(d[8*i +: 8]);
        if (c == 4'd5) begin
            expQ.push_back(8'h47);
            expQ.push_back(8'h47);
            for (int i = 1; i >= 0; i--) expQ.push_back(p[8*i +: 8]);
            for (int i = 3; i >= 0; i--) expQ.push_back(d[8*i +: 8]);
            expQ.push_back(8'h2E);
            expQ.push_back(8'h2E);
        end
        if (c == 4'd7) begin
            expQ.push_back(d[15:8]);
            expQ.push_back(d[7:0]);
            expQ.push_back(8'h2E);
            expQ.push_back(8'h2E);
        end
    endfunction

    task automatic runCmd(input logic [3:0] c, input logic [31:0] d,
                          input logic [15:0] p, input int rmode,
                          input int abortAt, input bit chg,
                          input int expCnt, input bit expErr);
        logic [7:0] got[$];
        int         cyc, doneCyc, waitN, n;
        bit         prevStall, rdy, aborted;
        logic [7:0] prevByte;
        buildFrame(c, d, p);
        waitN = 0;
        while (!CmdReady && waitN < 20) begin
            @(posedge Clk); #1;
            waitN++;
        end
        if (!CmdReady) begin
            check("cmdready_timeout", 64'(CmdReady), 64'd1);
            return;
        end
        Cmd = c;
        Data = d;
        PPR = p;
        CmdValid = 1'b1;
        ByteReady = 1'b0;
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        Cmd = 4'd0;
        if (chg) begin
            Data = 32'h0;
            PPR = 16'h0;
        end
        if (expQ.size() > 0) begin
            check("first_valid", 64'(ByteValid), 64'd1);
            check("first_busy", 64'(Busy), 64'd1);
            check("first_cmdready", 64'(CmdReady), 64'd0);
        end else begin
            check("unk_valid", 64'(ByteValid), 64'd0);
            check("unk_done", 64'(Done), 64'd1);
            check("unk_err", 64'(Err), 64'd1);
        end
        cyc = 1;
        doneCyc = -1;
        prevStall = 1'b0;
        prevByte = 8'h00;
        aborted = 1'b0;
        while (cyc < 300) begin
            if (Done) begin
                doneCyc = cyc;
                break;
            end
            if (prevStall) begin
                check("hold_valid", 64'(ByteValid), 64'd1);
                check("hold_data", 64'(ByteData), 64'(prevByte));
            end
            Abort = 1'b0;
            if (rmode == 0) rdy = 1'b1;
            else if (rmode == 1) rdy = (cyc % 3 == 0);
            else rdy = ($urandom_range(0, 1) == 1);
            if (ByteValid && abortAt >= 0 && !aborted &&
                got.size() == abortAt) begin
                rdy = 1'b0;
                Abort = 1'b1;
                aborted = 1'b1;
            end
            ByteReady = rdy;
            if (ByteValid && rdy) got.push_back(ByteData);
            prevStall = ByteValid && !rdy;
            prevByte = ByteData;
            @(posedge Clk); #1;
            cyc++;
        end
        Abort = 1'b0;
        ByteReady = 1'b0;
        if (doneCyc < 0) begin
            check("done_timeout", 64'(Done), 64'd1);
            return;
        end
        check("done_err", 64'(Err), 64'(expErr));
        check("byte_count", 64'(got.size()), 64'(expCnt));
        n = (got.size() < expCnt) ? got.size() : expCnt;
        for (int i = 0; i < n; i++)
            check($sformatf("byte%0d_cmd%0h", i, c), 64'(got[i]),
                  64'(expQ[i]));
        if (rmode == 0 && abortAt < 0)
            check("done_latency", 64'(doneCyc), 64'(expCnt + 1));
        @(posedge Clk); #1;
        check("post_done", 64'(Done), 64'd0);
        check("post_cmdready", 64'(CmdReady), 64'd1);
        check("post_busy", 64'(Busy), 64'd0);
    endtask

    initial begin
        int len, ab, cnt;
        logic [3:0] rc;
        logic [31:0] rd;
        logic [15:0] rp;

        tbl[0] = '{4'd1, 32'h0, 16'h0, 0, -1, 1'b0, 7, 1'b0};
        tbl[1] = '{4'd5, 32'hDEADBEEF, 16'h0400, 0, -1, 1'b1, 10, 1'b0};
        tbl[2] = '{4'd4, 32'hDEADBEEF, 16'h0, 1, -1, 1'b0, 4, 1'b0};
        tbl[3] = '{4'd6, 32'h0, 16'h0, 0, 0, 1'b0, 1, 1'b1};
        tbl[4] = '{4'hF, 32'h0, 16'h0, 0, -1, 1'b0, 0, 1'b1};
        tbl[5] = '{4'd3, 32'h0, 16'h0, 0, -1, 1'b0, 4, 1'b0};
        tbl[6] = '{4'd7, 32'h1234ABCD, 16'h0, 1, -1, 1'b0, 4, 1'b0};
        tbl[7] = '{4'd2, 32'h55, 16'h0, 0, -1, 1'b0, 0, 1'b1};

        RstN = 1'b0;
        CmdValid = 1'b0;
        Cmd = 4'd0;
        Data = 32'h0;
        PPR = 16'h0;
        Abort = 1'b0;
        ByteReady = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_cmdready", 64'(CmdReady), 64'd0);
        check("rst_valid", 64'(ByteValid), 64'd0);
        check("rst_data", 64'(ByteData), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_err", 64'(Err), 64'd0);
        RstN = 1'b1;
        @(posedge Clk); #1;
        check("cmdready_rise", 64'(CmdReady), 64'd1);

        for (int i = 0; i < 8; i++)
            runCmd(tbl[i].cmd, tbl[i].data, tbl[i].ppr, tbl[i].rmode,
                   tbl[i].abortAt, tbl[i].chg, tbl[i].expCnt,
                   tbl[i].expErr);

        Cmd = 4'd0;
        CmdValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check("idle0_cmdready", 64'(CmdReady), 64'd1);
            check("idle0_valid", 64'(ByteValid), 64'd0);
            check("idle0_busy", 64'(Busy), 64'd0);
        end
        CmdValid = 1'b0;

        Cmd = 4'd1;
        CmdValid = 1'b1;
        ByteReady = 1'b1;
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        Cmd = 4'd0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        check("midrst_byte3", 64'(ByteData), 64'h6C);
        #2 RstN = 1'b0;
        #1;
        check("midrst_valid", 64'(ByteValid), 64'd0);
        check("midrst_data", 64'(ByteData), 64'd0);
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_cmdready", 64'(CmdReady), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        ByteReady = 1'b0;
        @(posedge Clk); #1;
        check("midrst_hold_done", 64'(Done), 64'd0);
        RstN = 1'b1;
        @(posedge Clk); #1;
        check("midrst_cmdready", 64'(CmdReady), 64'd1);
        runCmd(4'd3, 32'h0, 16'h0, 0, -1, 1'b0, 4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(1, 15));
            rd = $urandom;
            rp = 16'($urandom);
            buildFrame(rc, rd, rp);
            len = expQ.size();
            ab = -1;
            if (len > 0 && $urandom_range(0, 4) == 0)
                ab = $urandom_range(0, len - 1);
            cnt = (ab >= 0) ? ab + 1 : len;
            runCmd(rc, rd, rp, 2, ab, 1'($urandom_range(0, 1)), cnt,
                   (len == 0) || (ab >= 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Command-driven frame sequencer: on each accepted command it snapshots Data/PPR, builds the corresponding reply frame (ID, start-ack, data, PPR+data, stop, temperature) and streams it byte-by-byte over a ready/valid interface to the byte-level UART transmitter. It is the next-generation host-reply path of the encoder tester. Over the existing manager it adds parametrised data/PPR widths, a command accept handshake, payload snapshotting, abort, and an error flag for unknown commands.

## Interface
- DATA_W, 32: encoder data width, multiple of 8, 8..64; sent MSB byte first.
- PPR_W, 16: PPR width, multiple of 8, 8..32.
- CMD_W, 4: command code width.
- Clk in 1: sole clock, rising edge.
- RstN in 1: reset, asynchronous, active-low.
- CmdValid in 1: command request.
- Cmd in CMD_W: command code, sampled at accept.
- CmdReady out 1: sequencer idle and can accept.
- Data in DATA_W: encoder data, snapshotted at accept.
- PPR in PPR_W: pulses-per-rev, snapshotted at accept.
- Abort in 1: terminate the current frame at the next byte boundary.
- ByteData out 8: byte to the UART.
- ByteValid out 1: ByteData valid.
- ByteReady in 1: UART accepts the byte.
- Busy out 1: frame in progress.
- Done out 1: one-cycle pulse at frame end (normal, aborted or error).
- Err out 1: one-cycle pulse, coincident with Done, when the command was unknown or the frame was aborted.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: CmdReady=1. Accept occurs when CmdValid & CmdReady. On accept: latch Cmd, Data and PPR; clear the byte index; compute frame length L; go to SEND.
- If the code is unknown: L=0, go straight to DONE with Err=1.
- Frames (hex, in send order):
  - ID (1): 48 65 6C 6C 6F 2E 2E (L=7).
  - START (3): 47 47 2E 2E (L=4).
  - DATA (4): Data bytes MSB first (L=DATA_W/8).
  - PPR (5): 47 47, PPR bytes MSB first, Data bytes MSB first, 2E 2E (L=6+PPR_W/8+DATA_W/8-2, i.e. 4+PPR_W/8+DATA_W/8).
  - STOP (6): 2A 2B (L=2).
  - TEMP (7): Data[15:8], Data[7:0], 2E 2E (L=4).
  - Code 0 (idle): ignored; it is never accepted and CmdReady stays high.
- SEND: ByteValid=1 and ByteData=frame[index].
  - On ByteValid & ByteReady: index+1.
  - If index was L-1, or Abort was latched, go to DONE.
- ByteData and ByteValid must stay stable until the handshake completes. ByteValid is never withdrawn mid-byte.
- Abort is sampled in any state other than IDLE and latched as a sticky flag, cleared on entry to IDLE. The frame stops after the in-flight byte's handshake. Abort seen in IDLE is ignored.
- DONE: ByteValid=0, Done=1, Err as flagged. Next state is IDLE.
- The index counter is sized to the maximum L and never wraps, because the transition to DONE occurs at L-1.

## Timing
- All outputs are registered.
- Reset values: CmdReady=0, ByteValid=0, ByteData=00, Busy=0, Done=0, Err=0. State is IDLE.
- CmdReady rises on the first Clk edge after RstN deasserts.
- Accept at edge N: the cycle after edge N has ByteValid=1, ByteData=byte0, Busy=1, CmdReady=0.
- Back-to-back: a handshake at edge M presents the next byte after edge M, with no bubble.
- With ByteReady held high: handshakes occur at edges N+1..N+L. Done=1 and Busy=1 in the cycle after edge N+L. CmdReady=1 and Busy=0 after edge N+L+1. Frame cost is L+2 cycles.
- Unknown command: Done=Err=1 in the cycle after accept, and no byte is sent.
- RstN asserted mid-frame: all outputs go to their reset values immediately and the frame is discarded, with no Done.
- Snapshot: changes to Data or PPR after accept do not affect the frame in flight.

## Structure
- Shared package tx_frame_pkg holds:
  - command codes CMD_IDLE, CMD_ID, CMD_START, CMD_DATA, CMD_PPR, CMD_STOP, CMD_TEMP;
  - ASCII constants 48/65/6C/6F/47/2E/2A/2B;
  - the state enum.
- Sub-module tx_frame_rom: combinational byte selector mapping (cmd, index, snapshot Data, snapshot PPR) to a byte, plus a length function. The FSM and counter stay in the top module.

## Test plan
- Cmd=1 with ByteReady tied high -> bytes 48 65 6C 6C 6F 2E 2E on consecutive cycles; Done one cycle after the last byte; CmdReady back 2 cycles after the last handshake.
- Cmd=5 with PPR=0x0400, Data=0xDEADBEEF, defaults -> 47 47 04 00 DE AD BE EF 2E 2E. Data changed to 0 one cycle after accept -> frame unchanged.
- Cmd=4 with ByteReady toggling 1-in-3 -> DE AD BE EF, each held stable while ByteReady=0, with no duplicates or drops.
- Cmd=6 with Abort pulsed during byte 0 (2A) while ByteReady=0 -> 2A is completed, 2B is never sent, Done=Err=1.
- Cmd=0xF -> no ByteValid, Done=Err=1 in the cycle after accept. Cmd=0 with CmdValid=1 -> nothing happens.
- RstN pulsed low during byte 3 of Cmd=1 -> outputs zero asynchronously; after release, a fresh Cmd=3 yields exactly 47 47 2E 2E.
